// File: rtl/adc_multi_readout_if.sv
// Bus bundle for the multi-channel ADC readout: sample input, trigger controls,
// per-channel FIFO write ports and status counters.
interface adc_multi_readout_if #(
    parameter int NCH   = 2,
    parameter int ADC_W = 14
);
    logic [NCH*ADC_W-1:0] adc_data;
    logic                 write_en;
    logic                 ext_trg;
    logic                 sw_trg;
    logic [NCH*32-1:0]    fifo_writedata;
    logic [NCH-1:0]       fifo_write;
    logic [NCH-1:0]       fifo_waitrequest;
    logic                 busy;
    logic [19:0]          trig_count;
    logic [15:0]          trg_lost;

    // The readout block masters the FIFO write ports
    modport master (
        input  adc_data, write_en, ext_trg, sw_trg, fifo_waitrequest,
        output fifo_writedata, fifo_write, busy, trig_count, trg_lost
    );

    modport slave (
        output adc_data, write_en, ext_trg, sw_trg, fifo_waitrequest,
        input  fifo_writedata, fifo_write, busy, trig_count, trg_lost
    );
endinterface

// File: rtl/adc_multi_readout.sv
// N-channel triggered ADC readout: circular pre-trigger buffers, post-trigger capture,
// and per-channel drain of header plus packed sample pairs into FIFO write ports.
module adc_multi_readout #(
    parameter int NCH   = 2,
    parameter int ADC_W = 14,
    parameter int DEPTH = 64,
    parameter int PRE   = 8,
    parameter int POST  = 24
) (
    input  logic                 clk_clk,
    input  logic                 reset_reset_n,
    adc_multi_readout_if.master  bus
);
    localparam int AW     = $clog2(DEPTH);
    localparam int NWORDS = 1 + (PRE + POST) / 2;
    localparam int KW     = $clog2(NWORDS + 1);

    typedef enum logic [2:0] {ST_IDLE, ST_FILL, ST_ARMED, ST_POST, ST_DRAIN} state_t;

    state_t            state, state_next;
    logic [AW-1:0]     wr_ptr, rd_base;
    logic [15:0]       fill_cnt, post_cnt;
    logic              ext_trg_q;
    logic              trig_edge, sampling, all_done;
    logic [19:0]       trig_count;
    logic [15:0]       trg_lost;
    logic [ADC_W-1:0]  mem   [NCH][DEPTH];
    logic [ADC_W-1:0]  rd_lo [NCH];
    logic [ADC_W-1:0]  rd_hi [NCH];
    logic [KW-1:0]     word_k [NCH];
    logic [KW-1:0]     next_k [NCH];
    logic [AW-1:0]     addr_lo [NCH];
    logic [NCH-1:0]    done, strobe, xfer;
    logic [NCH*32-1:0] fifo_wdata;

    assign trig_edge = (bus.ext_trg & ~ext_trg_q) | bus.sw_trg;
    assign sampling  = (state == ST_FILL) || (state == ST_ARMED) || (state == ST_POST);
    assign all_done  = &done;

    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) state <= ST_IDLE;
        else                state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (bus.write_en) state_next = ST_FILL;
            ST_FILL: begin
                if (!bus.write_en)                  state_next = ST_IDLE;
                else if (fill_cnt == 16'(PRE - 1))  state_next = ST_ARMED;
            end
            ST_ARMED: begin
                if (!bus.write_en)  state_next = ST_IDLE;
                else if (trig_edge) state_next = ST_POST;
            end
            ST_POST:  if (post_cnt == 16'(POST - 2)) state_next = ST_DRAIN;
            ST_DRAIN: if (all_done) state_next = bus.write_en ? ST_FILL : ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // The RAM read address follows the word index a channel will present next cycle,
    // so the registered read data is already aligned when that word is shown.
    always_comb begin
        done    = '0;
        strobe  = '0;
        xfer    = '0;
        next_k  = '{default: '0};
        addr_lo = '{default: '0};
        for (int c = 0; c < NCH; c++) begin
            done[c]    = (word_k[c] == KW'(NWORDS));
            strobe[c]  = (state == ST_DRAIN) && !done[c];
            xfer[c]    = strobe[c] & ~bus.fifo_waitrequest[c];
            next_k[c]  = word_k[c] + KW'(xfer[c]);
            addr_lo[c] = rd_base + (AW'(next_k[c]) << 1) - AW'(2);
        end
    end

    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            wr_ptr     <= '0;
            rd_base    <= '0;
            fill_cnt   <= '0;
            post_cnt   <= '0;
            ext_trg_q  <= 1'b0;
            trig_count <= '0;
            trg_lost   <= '0;
            word_k     <= '{default: '0};
        end else begin
            ext_trg_q <= bus.ext_trg;
            if (sampling) wr_ptr <= wr_ptr + AW'(1);
            fill_cnt <= (state == ST_FILL) ? fill_cnt + 16'd1 : 16'd0;
            post_cnt <= (state == ST_POST) ? post_cnt + 16'd1 : 16'd0;
            if (state == ST_ARMED && bus.write_en && trig_edge) begin
                trig_count <= trig_count + 20'd1;
                rd_base    <= wr_ptr - AW'(PRE);
            end
            if (trig_edge && (state == ST_FILL || state == ST_POST || state == ST_DRAIN)
                && trg_lost != 16'hFFFF)
                trg_lost <= trg_lost + 16'd1;
            for (int c = 0; c < NCH; c++)
                word_k[c] <= (state == ST_DRAIN) ? next_k[c] : '0;
        end
    end

    always_ff @(posedge clk_clk) begin
        for (int c = 0; c < NCH; c++) begin
            if (sampling) mem[c][wr_ptr] <= bus.adc_data[c*ADC_W +: ADC_W];
            rd_lo[c] <= mem[c][addr_lo[c]];
            rd_hi[c] <= mem[c][addr_lo[c] + AW'(1)];
        end
    end

    always_comb begin
        fifo_wdata = '0;
        for (int c = 0; c < NCH; c++) begin
            if (strobe[c]) begin
                if (word_k[c] == '0)
                    fifo_wdata[c*32 +: 32] = {8'hA5, 4'(c), trig_count};
                else
                    fifo_wdata[c*32 +: 32] = {16'(rd_hi[c]), 16'(rd_lo[c])};
            end
        end
    end

    assign bus.fifo_writedata = fifo_wdata;
    assign bus.fifo_write     = strobe;
    assign bus.busy           = (state == ST_POST) || (state == ST_DRAIN);
    assign bus.trig_count     = trig_count;
    assign bus.trg_lost       = trg_lost;
endmodule
